// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and the benches that drive
// the bit-sequence detectors.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int GAP_W = 8;

    localparam logic [3:0] PAT_1011 = 4'b1011;
    localparam logic [3:0] PAT_1101 = 4'b1101;

    // Width of a bit-index field for a pattern of max_len bits (never below 1).
    function automatic int len_w_f(input int max_len);
        return (max_len < 2) ? 1 : $clog2(max_len);
    endfunction

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Load and serial-output signals of serial_pattern_gen, seen from the user (master)
// and from the generator (slave).
interface serial_pattern_gen_if #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = seq_gen_pkg::len_w_f(MAX_LEN),
    parameter int REP_W   = 8
);
    // Handshake: a load transfers on a rising edge where load_valid && load_ready;
    // load_ready is high only while idle, and a request seen while busy is dropped.
    logic               load_valid;
    logic               load_ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len_m1;
    logic [REP_W-1:0]   rep_m1;
    logic               abort;
    logic               sequence_out;
    logic               seq_active;
    logic               done;

    modport master (
        output load_valid, pattern, len_m1, rep_m1, abort,
        input  load_ready, sequence_out, seq_active, done
    );

    modport slave (
        input  load_valid, pattern, len_m1, rep_m1, abort,
        output load_ready, sequence_out, seq_active, done
    );

endinterface

// File: rtl/seq_shift_reg.sv
// Captured pattern plus a bit-index down-counter; the index reloads to the
// captured length on the last bit so repeats need no extra load.
module seq_shift_reg #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_m1_i,
    output logic               last_bit_o,
    output logic               bit_out_o
);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
        end else if (load_i) begin
            pattern_q <= pattern_i;
            len_q     <= len_m1_i;
            idx_q     <= len_m1_i;
        end else if (shift_i) begin
            idx_q <= (idx_q == '0) ? len_q : idx_q - 1'b1;
        end
    end

    assign last_bit_o = (idx_q == '0);
    assign bit_out_o  = pattern_q[idx_q];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: shifts a loaded word out MSB-first, optionally
// repeating it with a fixed idle gap between repeats.
module serial_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int LEN_W      = len_w_f(MAX_LEN),
    parameter int REP_W      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_pattern_gen_if.slave  bus,
    output state_e               state_o
);

    localparam int               GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_LOAD_I[GAP_W-1:0];

    state_e             state_q, state_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               done_q, done_d;
    logic               load;
    logic               shift;
    logic               last_bit;
    logic               bit_out;

    seq_shift_reg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load),
        .shift_i    (shift),
        .pattern_i  (bus.pattern),
        .len_m1_i   (bus.len_m1),
        .last_bit_o (last_bit),
        .bit_out_o  (bit_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rep_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort is deliberately not looked at here, so it cannot block a load
                if (bus.load_valid) begin
                    load    = 1'b1;
                    rep_d   = bus.rep_m1;
                    state_d = SEND;
                end
            end
            SEND: begin
                shift = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    if (rep_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rep_d = rep_q - 1'b1;
                        if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only flops, so reset clears them at once and inputs never reach them.
    assign bus.load_ready   = (state_q == IDLE);
    assign bus.seq_active   = (state_q == SEND);
    assign bus.sequence_out = (state_q == SEND) & bit_out;
    assign bus.done         = done_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: two instances (no gap, two-cycle gap) driven by
// directed and random loads, checked per cycle against a queue-based stream model.
module tb_serial_pattern_gen;
    import seq_gen_pkg::*;

    logic clk;
    logic rst;

    logic [1:0]  lv;
    logic [1:0]  ab;
    logic [15:0] pat;
    logic [3:0]  len;
    logic [7:0]  rep;

    state_e state0, state1;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectation: {load_ready, done, seq_active, sequence_out}
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    serial_pattern_gen_if #(.MAX_LEN(16), .LEN_W(4), .REP_W(8)) bus0 ();
    serial_pattern_gen_if #(.MAX_LEN(16), .LEN_W(4), .REP_W(8)) bus1 ();

    assign bus0.load_valid = lv[0];
    assign bus0.abort      = ab[0];
    assign bus0.pattern    = pat;
    assign bus0.len_m1     = len;
    assign bus0.rep_m1     = rep;
    assign bus1.load_valid = lv[1];
    assign bus1.abort      = ab[1];
    assign bus1.pattern    = pat;
    assign bus1.len_m1     = len;
    assign bus1.rep_m1     = rep;

    wire [1:0][3:0] obs = {{bus1.load_ready, bus1.done, bus1.seq_active, bus1.sequence_out},
                           {bus0.load_ready, bus0.done, bus0.seq_active, bus0.sequence_out}};

    serial_pattern_gen #(.MAX_LEN(16), .REP_W(8), .GAP_CYCLES(0)) dut0 (
        .clock   (clk),
        .reset   (rst),
        .bus     (bus0),
        .state_o (state0)
    );

    serial_pattern_gen #(.MAX_LEN(16), .REP_W(8), .GAP_CYCLES(2)) dut1 (
        .clock   (clk),
        .reset   (rst),
        .bus     (bus1),
        .state_o (state1)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int qsize(input int s);
        return (s == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [3:0] pop_exp(input int s);
        if (s == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic push_exp(input int s, input logic [3:0] e);
        if (s == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic flush_exp(input int s);
        if (s == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    // Whole transfer as seen on the outputs: (len+1) bits per pass, MSB first,
    // gap idle cycles between passes, then one done cycle with load_ready high.
    task automatic push_stream(input int s, input logic [15:0] p, input int l, input int r, input int g);
        for (int k = 0; k <= r; k++) begin
            for (int i = l; i >= 0; i--) push_exp(s, {3'b001, p[i]});
            if (k < r) begin
                for (int j = 0; j < g; j++) push_exp(s, 4'b0000);
            end
        end
        push_exp(s, 4'b1100);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            logic [3:0] got;
            logic [3:0] want;
            got  = obs[s];
            want = (qsize(s) != 0) ? pop_exp(s) : 4'b1000;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mon%0d t=%0t {rdy,done,act,bit} got=%b exp=%b", s, $time, got, want);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, want);
        end
    endtask

    // Caller guarantees the selected instance is idle at the next rising edge.
    task automatic start_load(input int s, input logic [15:0] p, input int l, input int r);
        lv[s] = 1'b1;
        pat   = p;
        len   = 4'(l);
        rep   = 8'(r);
        @(posedge clk);
        #1;
        lv[s] = 1'b0;
        push_stream(s, p, l, r, (s == 1) ? 2 : 0);
        pat = 16'($urandom);
        len = 4'($urandom);
        rep = 8'($urandom);
    endtask

    task automatic wait_idle(input int s, input int budget);
        int n;
        n = 0;
        while (qsize(s) != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (qsize(s) != 0) begin
            errors++;
            $display("FAIL wait_idle%0d got=%0d pending exp=0 pending", s, qsize(s));
            flush_exp(s);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        rst = 1'b1;
        lv  = '0;
        ab  = '0;
        pat = '0;
        len = '0;
        rep = '0;
        repeat (2) @(negedge clk);
        check("reset_obs0", 32'(obs[0]), 32'h8);
        check("reset_obs1", 32'(obs[1]), 32'h8);
        check("reset_state0", 32'(state0), 32'(IDLE));
        #1;
        rst = 1'b0;
        step(1);

        // single shot, then repeats with junk above len_m1
        start_load(0, {12'h000, PAT_1011}, 3, 0);
        wait_idle(0, 50);
        start_load(0, {12'hFFF, PAT_1011}, 3, 2);
        wait_idle(0, 50);

        // two-cycle gap between repeats
        start_load(1, {12'h5A5, PAT_1011}, 3, 1);
        wait_idle(1, 50);

        // abort during the 3rd bit, new load the cycle after
        start_load(0, {12'h000, PAT_1011}, 3, 0);
        step(3);
        ab[0] = 1'b1;
        @(posedge clk);
        #1;
        ab[0] = 1'b0;
        flush_exp(0);
        check("abort_state", 32'(state0), 32'(IDLE));
        check("abort_ready", 32'(bus0.load_ready), 32'h1);
        start_load(0, {12'h000, PAT_1101}, 3, 0);
        wait_idle(0, 50);

        // abort in the gap; abort in idle does not block a load
        start_load(1, {12'h000, PAT_1101}, 3, 1);
        step(5);
        ab[1] = 1'b1;
        @(posedge clk);
        #1;
        ab[1] = 1'b0;
        flush_exp(1);
        check("abort_gap_state", 32'(state1), 32'(IDLE));
        ab[0] = 1'b1;
        start_load(0, {12'h000, PAT_1101}, 3, 1);
        ab[0] = 1'b0;
        wait_idle(0, 50);

        // ignored load while sending, then back-to-back load in the done cycle
        start_load(0, {12'h000, PAT_1011}, 3, 0);
        step(2);
        lv[0] = 1'b1;
        pat   = 16'hFFFF;
        len   = 4'd15;
        rep   = 8'd5;
        step(1);
        lv[0] = 1'b0;
        seen  = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            step(1);
            if (bus0.done === 1'b1) seen = 1;
        end
        check("b2b_done_seen", 32'(seen), 32'h1);
        check("b2b_ready_in_done", 32'(bus0.load_ready), 32'h1);
        start_load(0, {12'h000, PAT_1101}, 3, 1);
        wait_idle(0, 50);

        // asynchronous reset mid-send, then a 1-bit pattern on the first edge after
        start_load(0, 16'hFFFF, 15, 0);
        step(2);
        rst = 1'b1;
        #1;
        check("async_rst_obs0", 32'(obs[0]), 32'h8);
        check("async_rst_obs1", 32'(obs[1]), 32'h8);
        check("async_rst_state", 32'(state0), 32'(IDLE));
        flush_exp(0);
        #1;
        rst = 1'b0;
        start_load(0, 16'hA5A5, 0, 0);
        wait_idle(0, 50);

        // random loads on both instances, overlapping where the two are independent
        for (int t = 0; t < 40; t++) begin
            int s;
            s = int'($urandom_range(0, 1));
            wait_idle(s, 400);
            start_load(s, 16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            step(int'($urandom_range(0, 3)));
        end
        wait_idle(0, 400);
        wait_idle(1, 400);

        // maximal load: 16 bits x 256 passes
        start_load(0, 16'h8001, 15, 255);
        wait_idle(0, 5000);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

- Serial pattern generator: accepts a parallel pattern word over a valid/ready load interface and shifts it out MSB-first on a one-bit line, one bit per clock.
- Optionally repeats the pattern with a programmable idle gap between repeats.
- Drives the serial input of the team's bit-sequence detectors, and is the stimulus source for detector bring-up and on-chip self-test.

## Interface
Parameters:
- MAX_LEN, 16: maximum pattern length in bits (2..32)
- LEN_W, $clog2(MAX_LEN): width of len_m1
- REP_W, 8: width of rep_m1
- GAP_CYCLES, 0: idle cycles inserted between repeats (0..255)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and the reset values of all outputs immediately
- load_valid  in  1  pattern load request
- load_ready  out  1  high only in IDLE
- pattern  in  MAX_LEN  pattern bits; bit len_m1 is sent first
- len_m1  in  LEN_W  pattern length minus 1
- rep_m1  in  REP_W  number of transmissions minus 1
- abort  in  1  synchronous abort of the transfer in progress
- sequence_out  out  1  serial bit stream, registered
- seq_active  out  1  high while sequence_out carries a pattern bit
- done  out  1  one-cycle pulse after the final bit of the final repeat

## Operation
- Reset values: sequence_out=0, seq_active=0, done=0, load_ready=1 (state IDLE).
- States: IDLE, SEND, GAP.
- IDLE:
  - sequence_out=0.
  - On load_valid && load_ready: capture pattern, len_m1 and rep_m1; bit index ← len_m1; repeat counter ← rep_m1; go to SEND.
- SEND:
  - sequence_out = captured pattern[bit index]; seq_active=1; bit index decrements each cycle.
  - At bit index 0 with repeat counter 0: go to IDLE and pulse done.
  - At bit index 0 with repeat counter ≠0: decrement the repeat counter and reload bit index ← len_m1.
    - GAP_CYCLES=0: stay in SEND (back-to-back repeats).
    - Otherwise: go to GAP.
- GAP:
  - sequence_out=0, seq_active=0, for exactly GAP_CYCLES cycles, then SEND.
- Pattern bits above len_m1 are ignored.
- Inputs change after capture: no effect on the transfer in progress.
- abort in SEND or GAP: next edge → IDLE; sequence_out=0, seq_active=0; done not pulsed.
- abort in IDLE: ignored, and does not block a simultaneous load.
- load_valid outside IDLE: ignored; it is not queued.
- len_m1 = 0 is legal (1-bit pattern).
- Counters never wrap: a maximal load (len_m1 = MAX_LEN-1, rep_m1 all ones) sends exactly MAX_LEN·2^REP_W bits.

## Timing
- Acceptance edge is T0. The first pattern bit appears on sequence_out in the cycle after T0.
- Each bit is held exactly one cycle.
- Total transfer: (len_m1+1)·(rep_m1+1) + rep_m1·GAP_CYCLES cycles of SEND/GAP.
- done is high in the first IDLE cycle after the last bit. load_ready is also high in that cycle, so a new load can be accepted there.
  - Minimum spacing between transfers: one idle 0 bit.
- seq_active is registered alongside sequence_out; the two are cycle-aligned.
- Asynchronous reset mid-transfer: outputs go to reset values without waiting for a clock. The first load is accepted at the first rising edge after reset deasserts.

## Structure
- Shared package seq_gen_pkg holds:
  - state enum (IDLE, SEND, GAP)
  - LEN_W derivation helper
  - pattern constants used by benches: 4'b1011 and 4'b1101
- Natural sub-module: seq_shift_reg.
  - Holds the captured pattern and bit-index down-counter.
  - Ports: load, shift, last_bit, bit_out.
- The top level holds the FSM, repeat counter and gap counter.

## Test plan
- Single shot: pattern=16'h000B, len_m1=3, rep_m1=0, GAP_CYCLES=0 → sequence_out 1,0,1,1 on cycles T0+1..T0+4 with seq_active=1; done=1 at T0+5; load_ready=0 during T0+1..T0+4.
- Repeats, no gap: pattern 1011, rep_m1=2 → 101110111011 contiguous over 12 cycles; a single done pulse after the 12th bit.
- Gap: GAP_CYCLES=2, pattern 1011, rep_m1=1 → 1011,0,0,1011 with seq_active low during the two gap cycles; 10 cycles total.
- Abort: assert abort during the 3rd bit of a 1011 load → IDLE next edge; sequence_out=0; no done pulse; a new load accepted the cycle after.
- Back-to-back: assert a new load in the done cycle → exactly one 0 bit between the two patterns; a load_valid asserted during SEND is ignored.
- Reset: assert reset asynchronously mid-SEND → outputs 0 and load_ready=1 before the next edge; len_m1=0 with pattern bit 1 → single 1 then done.
